// File: rtl/teras_pkg.sv
// rtl/teras_pkg.sv - shared register map, status bit indices and Wishbone FSM state for teras_result_fifo
package teras_pkg;

  // Byte offsets of the Wishbone-visible registers (bits [3:2] decoded)
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  // STATUS register bit positions
  localparam int EMPTY_BIT     = 16;
  localparam int FULL_BIT      = 17;
  localparam int UNDERFLOW_BIT = 18;

  // Wishbone access FSM: one wait state, ack held for exactly one cycle
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/teras_sync_fifo.sv
// rtl/teras_sync_fifo.sv - synchronous FIFO with push/pop/flush, occupancy count and full/empty flags
module teras_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Flush wins over both push and pop; a word pushed on a flush edge is dropped
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks net push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/teras_result_fifo.sv
// rtl/teras_result_fifo.sv - result FIFO with Wishbone DATA/STATUS/CTRL port; optional level IRQ via TERAS_RESFIFO_IRQ_EN
module teras_result_fifo
  import teras_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rts_i,
  output logic              rtr_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic [CNT_W-1:0]  level_o,
  output logic              irq_o
);

  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  wb_state_t         state;
  logic              underflow;
  logic [3:0]        reg_off;
  logic              access;
  logic              rd_access;
  logic              wr_access;
  logic              push;
  logic              pop;
  logic              flush;
  logic              rd_underflow;
  logic              clr_underflow;
  logic [31:0]       status_word;
  logic [31:0]       rd_data;
  logic              unused_bits;

  // Accesses are only taken in IDLE, so the ACK cycle never re-triggers a pop
  assign reg_off   = {wb_adr_i[3:2], 2'b00};
  assign access    = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign rd_access = access && !wb_we_i;
  assign wr_access = access && wb_we_i;

  assign push          = rts_i && rtr_o;
  assign pop           = rd_access && (reg_off == ADDR_DATA) && !empty;
  assign rd_underflow  = rd_access && (reg_off == ADDR_DATA) && empty;
  assign clr_underflow = wr_access && (reg_off == ADDR_STATUS) && wb_dat_i[UNDERFLOW_BIT];
  assign flush         = wr_access && (reg_off == ADDR_CTRL) && wb_dat_i[0];

  assign rtr_o   = !full;
  assign level_o = count;

  teras_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .data   (data_i),
    .pop    (pop),
    .flush  (flush),
    .head   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // STATUS word assembled from live FIFO state and the sticky underflow flag
  always_comb begin
    status_word                = '0;
    status_word[CNT_W-1:0]     = count;
    status_word[EMPTY_BIT]     = empty;
    status_word[FULL_BIT]      = full;
    status_word[UNDERFLOW_BIT] = underflow;
  end

`ifdef TERAS_RESFIFO_IRQ_EN
  logic [7:0] threshold;

  // Threshold is loaded by every CTRL write; IRQ follows the count one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_access && (reg_off == ADDR_CTRL)) begin
        threshold <= wb_dat_i[15:8];
      end
      irq_o <= (threshold != 8'd0) && (32'(count) >= 32'(threshold));
    end
  end

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:19], wb_dat_i[17:16], wb_dat_i[7:1]};
`else
  assign irq_o       = 1'b0;
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:19], wb_dat_i[17:1]};
`endif

  // Read-data mux; writes return 0 so wb_dat_o only carries meaningful read results
  always_comb begin
    rd_data = '0;
    if (!wb_we_i) begin
      case (reg_off)
        ADDR_DATA:   rd_data = empty ? 32'd0 : 32'(head);
        ADDR_STATUS: rd_data = status_word;
`ifdef TERAS_RESFIFO_IRQ_EN
        ADDR_CTRL:   rd_data = 32'(threshold) << 8;
`endif
        default:     rd_data = '0;
      endcase
    end
  end

  // Wishbone FSM: perform access on entry to ACK, hold ack one cycle, keep read data until next access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state    <= ACK;
            wb_ack_o <= 1'b1;
            wb_dat_o <= rd_data;
            if (rd_underflow) begin
              underflow <= 1'b1;
            end else if (clr_underflow) begin
              underflow <= 1'b0;
            end
          end
        end
        ACK: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
